uart_rx_fifo: RTL and testbench

//  - Receive-side byte buffer directly downstream of the UART receiver (rx).
//  - Captures each byte rx presents on out/data_ready and stores it in a circular FIFO.
//  - Presents the bytes to the host/consumer through a read-enable interface.
//  - Decouples bursty serial arrival from a slower or irregular consumer; flags overrun.

---
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART rx. Captures one byte per rising edge of rx_ready.
// Latency: rd_en to rd_data/rd_valid is 1 clk. A byte arriving while full is dropped and sets sticky overrun.
// Optional afull flag is enabled by defining UART_RXF_AFULL_EN; otherwise afull is tied low.
module uart_rx_fifo #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                rx_ready,
    input  logic                rd_en,
    input  logic                clr_overrun,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                full,
    output logic [ADDR_W:0]     count,
    output logic                overrun,
    output logic                afull
);
    localparam int CW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, full_q;
    logic              rx_ready_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;
    logic              overrun_q, overrun_d;
    logic              push, pop, wr, drop;

    always_comb begin
        push = rx_ready & ~rx_ready_q;
        pop  = rd_en & ~empty_q;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        wr   = push & (~full_q | pop);
        drop = push & full_q & ~pop;

        wr_ptr_d  = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data_d = pop ? mem_q[rd_ptr_q] : rd_data_q;

        count_d = count_q;
        if (wr && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !wr)
            count_d = count_q - 1'b1;

        overrun_d = overrun_q;
        if (drop)
            overrun_d = 1'b1;
        else if (clr_overrun)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rx_ready_q <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH_C);
            rx_ready_q <= rx_ready;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= pop;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr)
            mem_q[wr_ptr_q] <= rx_data;
    end

`ifdef UART_RXF_AFULL_EN
    logic afull_q;
    always_ff @(posedge clk) begin
        if (reset)
            afull_q <= 1'b0;
        else
            afull_q <= (count_d >= CW'(AFULL_LEVEL));
    end
    assign afull = afull_q;
`else
    assign afull = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued at drive time and matched on rd_valid.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_ready = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, overrun, afull;
    logic [4:0] count;

    int total = 0;
    int bad = 0;
    logic [7:0] sb_q[$];

    uart_rx_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_LEVEL(12)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .rd_en(rd_en), .clr_overrun(clr_overrun), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .afull(afull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            if (sb_q.size() == 0)
                chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
            else
                chk("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; rd_en = 1'b0; clr_overrun = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drives one rx_ready rising edge (rx_ready must be low beforehand).
    task automatic push_byte(input logic [7:0] b, input logic rd, input logic clr, input logic expect_acc);
        @(posedge clk); #1;
        rx_data = b; rx_ready = 1'b1; rd_en = rd; clr_overrun = clr;
        if (expect_acc) sb_q.push_back(b);
        @(posedge clk); #1;
        rx_ready = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 rd_en = 1'b1;
            @(posedge clk); #1 rd_en = 1'b0;
        end
        @(negedge clk); #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with rx_ready held high, then reset-state checks
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_afull", 32'(afull), 0);
        rx_ready = 1'b0;
        push_byte(8'd157, 1'b0, 1'b0, 1'b1);
        chk("t1_count", 32'(count), 1);
        chk("t1_empty", 32'(empty), 0);

        // 2: single pop, rd_data holds afterwards
        pop_n(1);
        chk("t2_empty", 32'(empty), 1);
        repeat (4) @(posedge clk);
        #1 chk("t2_hold", 32'(rd_data), 157);

        // 3: fill, overrun, clr with drop, drain
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b1);
        chk("t3_full", 32'(full), 1);
        chk("t3_count16", 32'(count), 16);
        chk("t3_ovr_pre", 32'(overrun), 0);
        push_byte(8'hAA, 1'b0, 1'b0, 1'b0);
        chk("t3_overrun", 32'(overrun), 1);
        chk("t3_count_drop", 32'(count), 16);
        push_byte(8'hBB, 1'b0, 1'b1, 1'b0);
        chk("t3_clr_vs_drop", 32'(overrun), 1);
        @(posedge clk); #1 clr_overrun = 1'b1;
        @(posedge clk); #1 clr_overrun = 1'b0;
        chk("t3_clr", 32'(overrun), 0);
        pop_n(16);
        chk("t3_drained", 32'(sb_q.size()), 0);
        chk("t3_empty", 32'(empty), 1);

        // 4: push and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b1);
        push_byte(8'h55, 1'b1, 1'b0, 1'b1);
        chk("t4_count", 32'(count), 16);
        chk("t4_full", 32'(full), 1);
        chk("t4_overrun", 32'(overrun), 0);
        pop_n(16);
        chk("t4_drained", 32'(sb_q.size()), 0);
        chk("t4_empty", 32'(empty), 1);

        // 5: wrap pointers with one-at-a-time traffic; pop on empty
        do_reset();
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i * 7 + 3), 1'b0, 1'b0, 1'b1);
            pop_n(1);
        end
        chk("t5_drained", 32'(sb_q.size()), 0);
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        chk("t5_empty_rd_valid", 32'(rd_valid), 0);
        chk("t5_empty_rd_data", 32'(rd_data), 32'(8'(39 * 7 + 3)));
        chk("t5_empty_count", 32'(count), 0);

        // 5b: push on empty with rd_en in the same cycle -> write only
        push_byte(8'h3C, 1'b1, 1'b0, 1'b1);
        chk("t5b_rd_valid", 32'(rd_valid), 0);
        chk("t5b_count", 32'(count), 1);
        pop_n(1);
        chk("t5b_drained", 32'(sb_q.size()), 0);

        // 6: almost-full threshold
        do_reset();
        for (int i = 0; i < 11; i++) push_byte(8'(100 + i), 1'b0, 1'b0, 1'b1);
        chk("t6_afull_11", 32'(afull), 0);
        push_byte(8'd111, 1'b0, 1'b0, 1'b1);
`ifdef UART_RXF_AFULL_EN
        chk("t6_afull_12", 32'(afull), 1);
`else
        chk("t6_afull_12", 32'(afull), 0);
`endif
        pop_n(1);
        chk("t6_afull_pop", 32'(afull), 0);
        chk("t6_count", 32'(count), 11);
        pop_n(11);
        chk("t6_drained", 32'(sb_q.size()), 0);

        // reset mid-operation discards contents
        for (int i = 0; i < 5; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b1);
        do_reset();
        #1;
        chk("t7_count", 32'(count), 0);
        chk("t7_empty", 32'(empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
